// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera sensor configuration sequencer:
// FSM encoding, table markers and the default sensor register list.
package cam_cfg_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_FETCH     = 4'd1;
    localparam state_t ST_DECODE    = 4'd2;
    localparam state_t ST_WRITE     = 4'd3;
    localparam state_t ST_WAIT_DONE = 4'd4;
    localparam state_t ST_DELAY     = 4'd5;
    localparam state_t ST_GAP       = 4'd6;
    localparam state_t ST_DONE      = 4'd7;
    localparam state_t ST_ERROR     = 4'd8;

    localparam logic [15:0] END_MARK  = 16'hFFFF;
    localparam logic [7:0]  DELAY_REG = 8'hF0;

    function automatic int unsigned ms_cycles(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // Sensor bring-up list as {reg, val}; unlisted slots read as the end marker.
    function automatic logic [15:0] sensor_word(input logic [31:0] idx);
        case (idx)
            32'd0:   return 16'h1280;
            32'd1:   return 16'hF002;
            32'd2:   return 16'h1101;
            default: return END_MARK;
        endcase
    endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// Register table ROM with one cycle of read latency.
module cam_cfg_rom
    import cam_cfg_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rom_index,
    output logic [15:0]      rom_data
);

    logic [15:0] rom_data_d;
    logic [15:0] rom_data_q;

    always_comb begin
        rom_data_d = sensor_word(32'(rom_index));
    end

    always_ff @(posedge clk) begin
        rom_data_q <= rom_data_d;
    end

    assign rom_data = rom_data_q;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the {reg, val} table and issues one SCCB write per entry, with delay
// entries, NACK retries and sticky done/error status.
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 1000000,
    parameter logic [7:0]  DEV_ADDR   = 8'h42,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYCLES = 16,
    parameter logic        AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] rom_index,
    input  logic [15:0]      rom_data,
    output logic             i2c_req,
    output logic [7:0]       i2c_dev,
    output logic [7:0]       i2c_reg,
    output logic [7:0]       i2c_val,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_error,
    output logic [IDX_W-1:0] err_index
);

    localparam logic [31:0]      MS_LAST    = 32'(ms_cycles(CLK_HZ) - 1);
    localparam logic [31:0]      GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [7:0]       RETRY_LAST = 8'(MAX_RETRY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = '1;

    state_t           state_d, state_q;
    logic [IDX_W-1:0] index_d, index_q;
    logic [7:0]       retry_d, retry_q;
    logic [31:0]      cnt_d, cnt_q;
    logic [7:0]       ms_d, ms_q;
    logic [7:0]       reg_d, reg_q;
    logic [7:0]       val_d, val_q;
    logic             done_d, done_q;
    logic             error_d, error_q;
    logic [IDX_W-1:0] err_idx_d, err_idx_q;
    logic             auto_d, auto_q;

    logic             restart;
    state_t           adv_state;
    logic [IDX_W-1:0] adv_index;

    // Advancing past the last slot ends the table instead of wrapping.
    always_comb begin
        if (index_q == IDX_LAST) begin
            adv_state = ST_DONE;
            adv_index = index_q;
        end else begin
            adv_state = ST_FETCH;
            adv_index = index_q + IDX_W'(1);
        end
    end

    assign restart = ((state_q == ST_IDLE) && (start || auto_q)) ||
                     (((state_q == ST_DELAY) || (state_q == ST_GAP)) && start);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        ms_d      = ms_q;
        reg_d     = reg_q;
        val_d     = val_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        auto_d    = 1'b0;

        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (rom_data == END_MARK) begin
                    state_d = ST_DONE;
                end else if (rom_data[15:8] == DELAY_REG) begin
                    if (rom_data[7:0] == 8'd0) begin
                        state_d = adv_state;
                        index_d = adv_index;
                    end else begin
                        ms_d    = rom_data[7:0];
                        cnt_d   = MS_LAST;
                        state_d = ST_DELAY;
                    end
                end else begin
                    reg_d   = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        retry_d = 8'd0;
                        cnt_d   = GAP_LAST;
                        state_d = ST_GAP;
                    end else if (retry_q < RETRY_LAST) begin
                        retry_d = retry_q + 8'd1;
                        cnt_d   = GAP_LAST;
                        state_d = ST_GAP;
                    end else begin
                        err_idx_d = index_q;
                        state_d   = ST_ERROR;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (ms_q != 8'd1) begin
                    ms_d  = ms_q - 8'd1;
                    cnt_d = MS_LAST;
                end else begin
                    state_d = adv_state;
                    index_d = adv_index;
                end
            end
            ST_GAP: begin
                // A nonzero retry count means the same entry is re-issued.
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (retry_q != 8'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = adv_state;
                    index_d = adv_index;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            done_d    = 1'b0;
            error_d   = 1'b0;
            err_idx_d = '0;
            index_d   = '0;
            retry_d   = 8'd0;
            state_d   = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            retry_q   <= 8'd0;
            cnt_q     <= 32'd0;
            ms_q      <= 8'd0;
            reg_q     <= 8'd0;
            val_q     <= 8'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            auto_q    <= AUTO_START;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            ms_q      <= ms_d;
            reg_q     <= reg_d;
            val_q     <= val_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            auto_q    <= auto_d;
        end
    end

    assign rom_index = index_q;
    assign i2c_req   = (state_q == ST_WRITE);
    assign i2c_dev   = DEV_ADDR;
    assign i2c_reg   = reg_q;
    assign i2c_val   = val_q;
    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign cfg_done  = done_q;
    assign cfg_error = error_q;
    assign err_index = err_idx_q;

endmodule
